// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare/bimodal branch predictor with GHR recovery and saturating statistics
//
// Same-cycle taken/target prediction for the ID stage, trained by MEM-stage resolution.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   lookup_valid              ID instruction is valid
//   lookup_is_branch          ID instruction is a conditional branch
//   lookup_is_jump            ID instruction is JAL (always taken, never touches PHT/GHR)
//   lookup_pc, lookup_imm     PC and sign-extended immediate of the ID instruction
//   pred_taken                redirect fetch
//   pred_target               lookup_pc + lookup_imm
//   pred_index, pred_ghr      PHT index and pre-shift GHR, carried down to MEM
//   resolve_valid             a branch resolved in MEM this cycle
//   resolve_index, resolve_ghr  values carried with the resolving branch
//   resolve_taken             actual outcome
//   resolve_mispred           actual outcome differs from the prediction
//   stat_branches             saturating count of resolved branches
//   stat_mispreds             saturating count of mispredicted branches

module branch_predictor_gshare #(
  parameter int IDX_BITS  = 3,
  parameter int HIST_BITS = 3,
  parameter int MODE      = 1,
  parameter int STAT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lookup_valid,
  input  logic                 lookup_is_branch,
  input  logic                 lookup_is_jump,
  input  logic [31:0]          lookup_pc,
  input  logic [31:0]          lookup_imm,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  output logic [IDX_BITS-1:0]  pred_index,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 resolve_valid,
  input  logic [IDX_BITS-1:0]  resolve_index,
  input  logic [HIST_BITS-1:0] resolve_ghr,
  input  logic                 resolve_taken,
  input  logic                 resolve_mispred,
  output logic [STAT_W-1:0]    stat_branches,
  output logic [STAT_W-1:0]    stat_mispreds
);

  localparam int PHT_SIZE = 1 << IDX_BITS;

  logic [1:0]           pht [PHT_SIZE];
  logic [HIST_BITS-1:0] ghr;
  logic [HIST_BITS-1:0] ghr_next;
  logic [IDX_BITS-1:0]  pc_idx;
  logic [IDX_BITS-1:0]  ghr_ext;
  logic [IDX_BITS-1:0]  idx;
  logic                 lookup_shift;
  logic [1:0]           pht_old;
  logic [1:0]           pht_new;

  // ---------------------------------------------------------------------------
  // Index and prediction (combinational, zero latency)
  // ---------------------------------------------------------------------------
  assign pc_idx  = lookup_pc[IDX_BITS+1:2];
  // History is narrower than or equal to the index; it folds into the low bits.
  assign ghr_ext = IDX_BITS'(ghr);

  always_comb begin
    idx = pc_idx;
    if (MODE != 0) begin
      idx = pc_idx ^ ghr_ext;
    end
  end

  assign pred_index  = idx;
  assign pred_ghr    = ghr;
  assign pred_target = lookup_pc + lookup_imm;
  assign pred_taken  = lookup_valid & (lookup_is_jump | (lookup_is_branch & pht[idx][1]));

  // A jump flagged alongside a branch is still a jump: it must not shift history.
  assign lookup_shift = lookup_valid & lookup_is_branch & ~lookup_is_jump;

  // ---------------------------------------------------------------------------
  // Global history: mispredict recovery overrides the speculative shift, since
  // the instruction doing the lookup is younger and is being flushed.
  // The left shift drops the oldest bit; for HIST_BITS=1 it leaves just the new bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    ghr_next = ghr;
    if (resolve_valid && resolve_mispred) begin
      ghr_next = (resolve_ghr << 1) | HIST_BITS'(resolve_taken);
    end else if (lookup_shift) begin
      ghr_next = (ghr << 1) | HIST_BITS'(pred_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else begin
      ghr <= ghr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern history table: 2-bit saturating counters, trained at resolve.
  // Lookups in the same cycle see the pre-update value (no bypass).
  // ---------------------------------------------------------------------------
  assign pht_old = pht[resolve_index];

  always_comb begin
    pht_new = pht_old;
    if (resolve_taken) begin
      if (pht_old != 2'b11) begin
        pht_new = pht_old + 2'd1;
      end
    end else begin
      if (pht_old != 2'b00) begin
        pht_new = pht_old - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_SIZE; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (resolve_valid) begin
      pht[resolve_index] <= pht_new;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics: saturate at all-ones rather than wrap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispreds <= '0;
    end else if (resolve_valid) begin
      if (stat_branches != '1) begin
        stat_branches <= stat_branches + STAT_W'(1);
      end
      if (resolve_mispred && (stat_mispreds != '1)) begin
        stat_mispreds <= stat_mispreds + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - directed and randomized checks of branch_predictor_gshare against a reference model

module tb_branch_predictor_gshare;

  localparam int IDX_BITS  = 3;
  localparam int HIST_BITS = 3;
  localparam int STAT_W    = 4;
  localparam int NPHT      = 8;
  localparam int NHIST     = 8;
  localparam int SMAX      = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 lookup_valid;
  logic                 lookup_is_branch;
  logic                 lookup_is_jump;
  logic [31:0]          lookup_pc;
  logic [31:0]          lookup_imm;
  logic                 pred_taken;
  logic [31:0]          pred_target;
  logic [IDX_BITS-1:0]  pred_index;
  logic [HIST_BITS-1:0] pred_ghr;
  logic                 resolve_valid;
  logic [IDX_BITS-1:0]  resolve_index;
  logic [HIST_BITS-1:0] resolve_ghr;
  logic                 resolve_taken;
  logic                 resolve_mispred;
  logic [STAT_W-1:0]    stat_branches;
  logic [STAT_W-1:0]    stat_mispreds;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int pht_m [NPHT];
  int ghr_m;
  int nb_m;
  int nm_m;
  int ghr_saved;

  always #5 clk = ~clk;

  branch_predictor_gshare #(
    .IDX_BITS (IDX_BITS),
    .HIST_BITS(HIST_BITS),
    .MODE     (1),
    .STAT_W   (STAT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_valid    (lookup_valid),
    .lookup_is_branch(lookup_is_branch),
    .lookup_is_jump  (lookup_is_jump),
    .lookup_pc       (lookup_pc),
    .lookup_imm      (lookup_imm),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .pred_index      (pred_index),
    .pred_ghr        (pred_ghr),
    .resolve_valid   (resolve_valid),
    .resolve_index   (resolve_index),
    .resolve_ghr     (resolve_ghr),
    .resolve_taken   (resolve_taken),
    .resolve_mispred (resolve_mispred),
    .stat_branches   (stat_branches),
    .stat_mispreds   (stat_mispreds)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx();
    return ((int'(lookup_pc) >>> 2) & (NPHT - 1)) ^ ghr_m;
  endfunction

  function automatic int m_taken();
    if (!lookup_valid) return 0;
    if (lookup_is_jump) return 1;
    if (lookup_is_branch && pht_m[m_idx()] >= 2) return 1;
    return 0;
  endfunction

  // PC that lands on a chosen PHT index given the model's current history
  function automatic logic [31:0] pc_for(input int want);
    return 32'(((want ^ ghr_m) & (NPHT - 1)) << 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NPHT; i++) pht_m[i] = 1;
    ghr_m = 0;
    nb_m  = 0;
    nm_m  = 0;
  endtask

  task automatic model_update();
    int tk;
    int ri;
    tk = m_taken();
    ri = int'(resolve_index);
    if (rst) return;
    if (resolve_valid) begin
      if (resolve_taken) pht_m[ri] = (pht_m[ri] < 3) ? pht_m[ri] + 1 : 3;
      else               pht_m[ri] = (pht_m[ri] > 0) ? pht_m[ri] - 1 : 0;
      nb_m = (nb_m < SMAX) ? nb_m + 1 : SMAX;
      if (resolve_mispred) nm_m = (nm_m < SMAX) ? nm_m + 1 : SMAX;
    end
    if (resolve_valid && resolve_mispred)
      ghr_m = (int'(resolve_ghr) * 2 + int'(resolve_taken)) % NHIST;
    else if (lookup_valid && lookup_is_branch && !lookup_is_jump)
      ghr_m = (ghr_m * 2 + tk) % NHIST;
  endtask

  task automatic check_model();
    chk("pred_taken", 32'(pred_taken), 32'(m_taken()));
    chk("pred_target", pred_target, lookup_pc + lookup_imm);
    if (lookup_valid) begin
      chk("pred_index", 32'(pred_index), 32'(m_idx()));
      chk("pred_ghr", 32'(pred_ghr), 32'(ghr_m));
    end
    chk("stat_branches", 32'(stat_branches), 32'(nb_m));
    chk("stat_mispreds", 32'(stat_mispreds), 32'(nm_m));
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    lookup_valid     = 1'b0;
    lookup_is_branch = 1'b0;
    lookup_is_jump   = 1'b0;
    lookup_pc        = 32'h0;
    lookup_imm       = 32'h0;
    resolve_valid    = 1'b0;
    resolve_index    = '0;
    resolve_ghr      = '0;
    resolve_taken    = 1'b0;
    resolve_mispred  = 1'b0;
  endtask

  task automatic set_lookup(input logic br, input logic jp, input logic [31:0] pc, input logic [31:0] imm);
    lookup_valid     = 1'b1;
    lookup_is_branch = br;
    lookup_is_jump   = jp;
    lookup_pc        = pc;
    lookup_imm       = imm;
  endtask

  task automatic set_resolve(input int ri, input int rg, input logic rt, input logic rm);
    resolve_valid   = 1'b1;
    resolve_index   = IDX_BITS'(ri);
    resolve_ghr     = HIST_BITS'(rg);
    resolve_taken   = rt;
    resolve_mispred = rm;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stat_branches", 32'(stat_branches), 32'd0);
    chk("reset_stat_mispreds", 32'(stat_mispreds), 32'd0);
    rst = 1'b0;
    tick();

    // 1: first lookup after reset
    set_lookup(1'b1, 1'b0, 32'h10, 32'h20);
    at_neg();
    chk("t1_taken", 32'(pred_taken), 32'd0);
    chk("t1_target", pred_target, 32'h30);
    chk("t1_index", 32'(pred_index), 32'd4);
    chk("t1_ghr", 32'(pred_ghr), 32'd0);
    tick();

    // 2: train index 4 up, then down with saturation at both ends
    idle();
    set_resolve(4, 0, 1'b1, 1'b0);
    repeat (2) begin at_neg(); tick(); end
    idle();
    set_lookup(1'b1, 1'b0, 32'h10, 32'h0);
    at_neg();
    chk("t2_sat_taken", 32'(pred_taken), 32'd1);
    tick();
    idle();
    set_resolve(4, 0, 1'b0, 1'b0);
    repeat (5) begin at_neg(); tick(); end
    idle();
    set_lookup(1'b1, 1'b0, pc_for(4), 32'h0);
    at_neg();
    chk("t2_floor_nt", 32'(pred_taken), 32'd0);
    tick();
    idle();
    set_resolve(4, 0, 1'b1, 1'b0);
    at_neg(); tick();
    idle();
    set_lookup(1'b1, 1'b0, pc_for(4), 32'h0);
    at_neg();
    chk("t2_floor_plus1", 32'(pred_taken), 32'd0);
    tick();
    idle();
    set_resolve(4, 0, 1'b1, 1'b0);
    at_neg(); tick();
    idle();
    set_lookup(1'b1, 1'b0, pc_for(4), 32'h0);
    at_neg();
    chk("t2_floor_plus2", 32'(pred_taken), 32'd1);
    tick();

    // 3: jump predicts taken and leaves history alone
    idle();
    ghr_saved = ghr_m;
    set_lookup(1'b0, 1'b1, 32'h100, 32'hFFFF_FFF8);
    at_neg();
    chk("t3_taken", 32'(pred_taken), 32'd1);
    chk("t3_target", pred_target, 32'hF8);
    tick();
    set_lookup(1'b0, 1'b0, 32'h0, 32'h0);
    at_neg();
    chk("t3_ghr_kept", 32'(pred_ghr), 32'(ghr_saved));
    tick();

    // 4: mispredict recovery wins over same-cycle speculative shift
    idle();
    set_lookup(1'b1, 1'b0, pc_for(4), 32'h4);
    set_resolve(7, 3'b010, 1'b1, 1'b1);
    at_neg(); tick();
    idle();
    set_lookup(1'b0, 1'b0, 32'h0, 32'h0);
    at_neg();
    chk("t4_ghr_recover", 32'(pred_ghr), 32'b101);
    tick();

    // 5: same-cycle resolve and lookup on index 2 (no bypass)
    idle();
    set_lookup(1'b1, 1'b0, pc_for(2), 32'h8);
    set_resolve(2, 0, 1'b1, 1'b0);
    at_neg();
    chk("t5_no_bypass", 32'(pred_taken), 32'd0);
    tick();
    idle();
    set_lookup(1'b1, 1'b0, pc_for(2), 32'h8);
    at_neg();
    chk("t5_next_cycle", 32'(pred_taken), 32'd1);
    tick();

    // 6: statistics saturate, then async reset clears them mid-burst
    idle();
    repeat (16) begin
      set_resolve(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      at_neg(); tick();
    end
    at_neg();
    chk("t6_sat_branches", 32'(stat_branches), 32'hF);
    chk("t6_sat_mispreds", 32'(stat_mispreds), 32'hF);
    tick();
    at_neg();
    chk("t6_hold_branches", 32'(stat_branches), 32'hF);
    chk("t6_hold_mispreds", 32'(stat_mispreds), 32'hF);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_branches", 32'(stat_branches), 32'd0);
    chk("t6_rst_mispreds", 32'(stat_mispreds), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    idle();
    set_lookup(1'b1, 1'b0, 32'h10, 32'h20);
    at_neg();
    chk("t6_post_taken", 32'(pred_taken), 32'd0);
    chk("t6_post_index", 32'(pred_index), 32'd4);
    chk("t6_post_ghr", 32'(pred_ghr), 32'd0);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      lookup_valid     = 1'($urandom_range(0, 3) != 0);
      lookup_is_branch = 1'($urandom_range(0, 1));
      lookup_is_jump   = 1'($urandom_range(0, 4) == 0);
      lookup_pc        = $urandom;
      lookup_imm       = $urandom;
      if ($urandom_range(0, 1) == 1)
        set_resolve(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      at_neg();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
